vanilla_sb_stall_profiler: RTL and testbench

Downstream consumer of the per-register integer and float scoreboard info vectors; lives in the vanilla core testbench profiling layer beside the scoreboard tracker. Each cycle the ID stage holds on a dependency hazard, it attributes the stall to exactly one scoreboard category and increments that category's saturating counter. It also tracks total dependency-stall cycles and the longest consecutive stall run, and exposes a snapshot/clear and registered read port.

---
 rtl/vanilla_sb_stall_profiler.sv | 200 ++++++++++++++++++++
 tb/tb_vanilla_sb_stall_profiler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vanilla_sb_stall_profiler.sv
// Dependency-stall profiler: attributes each counted ID stall to one scoreboard category,
// keeps saturating live counters, and exposes snapshot shadows through a registered read port.
package vanilla_sb_pkg;
    localparam int reg_els_gp        = 32;
    localparam int reg_addr_width_gp = $clog2(reg_els_gp);

    typedef struct packed {
        logic idiv;
        logic remote_dram_load;
        logic remote_global_load;
        logic remote_group_load;
        logic remote_dram_amo;
        logic remote_dram_seq_load;
    } vanilla_isb_info_s;

    typedef struct packed {
        logic fdiv_fsqrt;
        logic remote_dram_load;
        logic remote_global_load;
        logic remote_group_load;
        logic remote_dram_seq_load;
    } vanilla_fsb_info_s;
endpackage

module vanilla_sb_stall_profiler
    import vanilla_sb_pkg::*;
#(
    parameter int ctr_width_p       = 32,
    parameter int reg_addr_width_lp = reg_addr_width_gp
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          stall_depend_i,
    input  logic                          stall_all_i,
    input  logic                          flush_i,
    input  logic [reg_addr_width_lp-1:0]  int_rs1_i,
    input  logic [reg_addr_width_lp-1:0]  int_rs2_i,
    input  logic [reg_addr_width_lp-1:0]  int_rd_i,
    input  logic [reg_addr_width_lp-1:0]  float_rs1_i,
    input  logic [reg_addr_width_lp-1:0]  float_rs2_i,
    input  logic [reg_addr_width_lp-1:0]  float_rs3_i,
    input  logic [reg_addr_width_lp-1:0]  float_rd_i,
    input  logic                          int_rs1_v_i,
    input  logic                          int_rs2_v_i,
    input  logic                          int_rd_v_i,
    input  logic                          float_rs1_v_i,
    input  logic                          float_rs2_v_i,
    input  logic                          float_rs3_v_i,
    input  logic                          float_rd_v_i,
    input  vanilla_isb_info_s             int_sb_i   [reg_els_gp],
    input  vanilla_fsb_info_s             float_sb_i [reg_els_gp],
    input  logic                          snapshot_v_i,
    input  logic                          rd_v_i,
    input  logic [3:0]                    rd_idx_i,
    output logic                          rd_v_o,
    output logic [ctr_width_p-1:0]        rd_data_o
);
    localparam int num_live_lp   = 12;
    localparam int num_shadow_lp = 14;
    localparam logic [3:0] cat_unknown_lp = 4'd11;

    typedef logic [ctr_width_p-1:0] ctr_t;

    function automatic ctr_t sat_inc(input ctr_t v);
        return (&v) ? v : v + ctr_t'(1);
    endfunction

    // Struct MSB is the lowest category, so the last set bit visited wins.
    function automatic logic [3:0] int_cat(input vanilla_isb_info_s e);
        logic [5:0] b;
        logic [3:0] r;
        b = e;
        r = '0;
        for (int k = 0; k < 6; k++) begin
            if (b[k]) r = 4'(5 - k);
        end
        return r;
    endfunction

    function automatic logic [3:0] float_cat(input vanilla_fsb_info_s e);
        logic [4:0] b;
        logic [3:0] r;
        b = e;
        r = 4'd6;
        for (int k = 0; k < 5; k++) begin
            if (b[k]) r = 4'(10 - k);
        end
        return r;
    endfunction

    logic                  counted;
    logic [6:0]            haz;
    logic [3:0]            op_cat [7];
    logic [3:0]            cat;
    vanilla_isb_info_s     e_irs1, e_irs2, e_ird;
    vanilla_fsb_info_s     e_frs1, e_frs2, e_frs3, e_frd;

    ctr_t live_q [num_live_lp];
    ctr_t live_d [num_live_lp];
    ctr_t live_upd [num_live_lp];
    ctr_t shadow_q [num_shadow_lp];
    ctr_t shadow_d [num_shadow_lp];
    ctr_t total_q, total_d, total_upd;
    ctr_t max_q, max_d, max_upd;
    ctr_t run_q, run_d, run_inc;
    ctr_t rd_data_q, rd_data_d;
    logic rd_v_q;

    assign counted = stall_depend_i & ~stall_all_i & ~flush_i;

    always_comb begin
        e_irs1 = int_sb_i[int_rs1_i];
        e_irs2 = int_sb_i[int_rs2_i];
        e_ird  = int_sb_i[int_rd_i];
        e_frs1 = float_sb_i[float_rs1_i];
        e_frs2 = float_sb_i[float_rs2_i];
        e_frs3 = float_sb_i[float_rs3_i];
        e_frd  = float_sb_i[float_rd_i];

        // Bit position is operand priority: 0 is checked first.
        haz[0] = int_rs1_v_i   && (int_rs1_i != '0) && (|e_irs1);
        haz[1] = int_rs2_v_i   && (int_rs2_i != '0) && (|e_irs2);
        haz[2] = float_rs1_v_i && (|e_frs1);
        haz[3] = float_rs2_v_i && (|e_frs2);
        haz[4] = float_rs3_v_i && (|e_frs3);
        haz[5] = int_rd_v_i    && (int_rd_i != '0) && (|e_ird);
        haz[6] = float_rd_v_i  && (|e_frd);

        op_cat[0] = int_cat(e_irs1);
        op_cat[1] = int_cat(e_irs2);
        op_cat[2] = float_cat(e_frs1);
        op_cat[3] = float_cat(e_frs2);
        op_cat[4] = float_cat(e_frs3);
        op_cat[5] = int_cat(e_ird);
        op_cat[6] = float_cat(e_frd);

        cat = cat_unknown_lp;
        for (int k = 6; k >= 0; k--) begin
            if (haz[k]) cat = op_cat[k];
        end
    end

    always_comb begin
        for (int k = 0; k < num_live_lp; k++) begin
            live_upd[k] = (counted && (cat == 4'(k))) ? sat_inc(live_q[k]) : live_q[k];
        end
        total_upd = counted ? sat_inc(total_q) : total_q;
        run_inc   = sat_inc(run_q);
        max_upd   = (counted && (run_inc > max_q)) ? run_inc : max_q;

        if (counted)          run_d = run_inc;
        else if (stall_all_i) run_d = run_q;
        else                  run_d = '0;

        live_d   = live_upd;
        total_d  = total_upd;
        max_d    = max_upd;
        shadow_d = shadow_q;
        if (snapshot_v_i) begin
            for (int k = 0; k < num_live_lp; k++) begin
                shadow_d[k] = live_upd[k];
                live_d[k]   = '0;
            end
            shadow_d[12] = max_upd;
            shadow_d[13] = total_upd;
            total_d      = '0;
            max_d        = '0;
        end

        // Reading from shadow_d gives snapshot-then-read ordering in the same cycle.
        rd_data_d = rd_data_q;
        if (rd_v_i) begin
            rd_data_d = (rd_idx_i < 4'(num_shadow_lp)) ? shadow_d[rd_idx_i] : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int k = 0; k < num_live_lp; k++)   live_q[k]   <= '0;
            for (int k = 0; k < num_shadow_lp; k++) shadow_q[k] <= '0;
            total_q   <= '0;
            max_q     <= '0;
            run_q     <= '0;
            rd_v_q    <= 1'b0;
            rd_data_q <= '0;
        end else begin
            live_q    <= live_d;
            shadow_q  <= shadow_d;
            total_q   <= total_d;
            max_q     <= max_d;
            run_q     <= run_d;
            rd_v_q    <= rd_v_i;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_v_o    = rd_v_q;
    assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_vanilla_sb_stall_profiler.sv
// Bench for vanilla_sb_stall_profiler: directed plan scenarios plus random stalls, checked
// against a category-count model on a 32-bit and an 8-bit counter instance.
module tb_vanilla_sb_stall_profiler;
    import vanilla_sb_pkg::*;

    localparam int AW = reg_addr_width_gp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, stall_depend, stall_all, flush, snapshot, rd_v;
    logic [3:0] rd_idx;
    logic [AW-1:0] int_rs1, int_rs2, int_rd, float_rs1, float_rs2, float_rs3, float_rd;
    logic int_rs1_v, int_rs2_v, int_rd_v, float_rs1_v, float_rs2_v, float_rs3_v, float_rd_v;
    vanilla_isb_info_s int_sb   [reg_els_gp];
    vanilla_fsb_info_s float_sb [reg_els_gp];
    logic        rd_v32, rd_v8;
    logic [31:0] rd_data32;
    logic [7:0]  rd_data8;

    vanilla_sb_stall_profiler #(.ctr_width_p(32)) dut32 (
        .clk_i(clk), .reset_n_i(reset_n), .stall_depend_i(stall_depend), .stall_all_i(stall_all),
        .flush_i(flush), .int_rs1_i(int_rs1), .int_rs2_i(int_rs2), .int_rd_i(int_rd),
        .float_rs1_i(float_rs1), .float_rs2_i(float_rs2), .float_rs3_i(float_rs3), .float_rd_i(float_rd),
        .int_rs1_v_i(int_rs1_v), .int_rs2_v_i(int_rs2_v), .int_rd_v_i(int_rd_v),
        .float_rs1_v_i(float_rs1_v), .float_rs2_v_i(float_rs2_v), .float_rs3_v_i(float_rs3_v),
        .float_rd_v_i(float_rd_v), .int_sb_i(int_sb), .float_sb_i(float_sb),
        .snapshot_v_i(snapshot), .rd_v_i(rd_v), .rd_idx_i(rd_idx),
        .rd_v_o(rd_v32), .rd_data_o(rd_data32));

    vanilla_sb_stall_profiler #(.ctr_width_p(8)) dut8 (
        .clk_i(clk), .reset_n_i(reset_n), .stall_depend_i(stall_depend), .stall_all_i(stall_all),
        .flush_i(flush), .int_rs1_i(int_rs1), .int_rs2_i(int_rs2), .int_rd_i(int_rd),
        .float_rs1_i(float_rs1), .float_rs2_i(float_rs2), .float_rs3_i(float_rs3), .float_rd_i(float_rd),
        .int_rs1_v_i(int_rs1_v), .int_rs2_v_i(int_rs2_v), .int_rd_v_i(int_rd_v),
        .float_rs1_v_i(float_rs1_v), .float_rs2_v_i(float_rs2_v), .float_rs3_v_i(float_rs3_v),
        .float_rd_v_i(float_rd_v), .int_sb_i(int_sb), .float_sb_i(float_sb),
        .snapshot_v_i(snapshot), .rd_v_i(rd_v), .rd_idx_i(rd_idx),
        .rd_v_o(rd_v8), .rd_data_o(rd_data8));

    int n_pass = 0;
    int n_chk  = 0;

    // Model: unbounded event counts; saturation is applied as a clamp at compare time.
    longint unsigned cnt [14];
    longint unsigned shadow_m [14];
    longint unsigned run_m;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic longint unsigned clamp(input longint unsigned v, input int w);
        longint unsigned lim;
        lim = (64'd1 << w) - 64'd1;
        return (v > lim) ? lim : v;
    endfunction

    function automatic int icat(input vanilla_isb_info_s e);
        if (e.idiv)               return 0;
        if (e.remote_dram_load)   return 1;
        if (e.remote_global_load) return 2;
        if (e.remote_group_load)  return 3;
        if (e.remote_dram_amo)    return 4;
        return 5;
    endfunction

    function automatic int fcat(input vanilla_fsb_info_s e);
        if (e.fdiv_fsqrt)         return 6;
        if (e.remote_dram_load)   return 7;
        if (e.remote_global_load) return 8;
        if (e.remote_group_load)  return 9;
        return 10;
    endfunction

    function automatic int model_cat();
        if (int_rs1_v && int_rs1 != 0 && int_sb[int_rs1] != 0)  return icat(int_sb[int_rs1]);
        if (int_rs2_v && int_rs2 != 0 && int_sb[int_rs2] != 0)  return icat(int_sb[int_rs2]);
        if (float_rs1_v && float_sb[float_rs1] != 0)            return fcat(float_sb[float_rs1]);
        if (float_rs2_v && float_sb[float_rs2] != 0)            return fcat(float_sb[float_rs2]);
        if (float_rs3_v && float_sb[float_rs3] != 0)            return fcat(float_sb[float_rs3]);
        if (int_rd_v && int_rd != 0 && int_sb[int_rd] != 0)    return icat(int_sb[int_rd]);
        if (float_rd_v && float_sb[float_rd] != 0)              return fcat(float_sb[float_rd]);
        return 11;
    endfunction

    task automatic clear_inputs();
        stall_depend = 0; stall_all = 0; flush = 0; snapshot = 0; rd_v = 0; rd_idx = 0;
        int_rs1 = 0; int_rs2 = 0; int_rd = 0; float_rs1 = 0; float_rs2 = 0; float_rs3 = 0; float_rd = 0;
        int_rs1_v = 0; int_rs2_v = 0; int_rd_v = 0;
        float_rs1_v = 0; float_rs2_v = 0; float_rs3_v = 0; float_rd_v = 0;
        for (int i = 0; i < reg_els_gp; i++) begin
            int_sb[i]   = '0;
            float_sb[i] = '0;
        end
    endtask

    task automatic tick();
        bit counted, exp_rdv;
        longint unsigned exp_rd;
        exp_rdv = 0;
        exp_rd  = 0;
        @(posedge clk);
        if (!reset_n) begin
            for (int k = 0; k < 14; k++) begin cnt[k] = 0; shadow_m[k] = 0; end
            run_m = 0;
        end else begin
            counted = stall_depend && !stall_all && !flush;
            if (counted) begin
                cnt[model_cat()]++;
                cnt[13]++;
                run_m++;
                if (run_m > cnt[12]) cnt[12] = run_m;
            end else if (!stall_all) begin
                run_m = 0;
            end
            if (snapshot) begin
                for (int k = 0; k < 14; k++) begin shadow_m[k] = cnt[k]; cnt[k] = 0; end
            end
            if (rd_v) begin
                exp_rdv = 1;
                exp_rd  = (rd_idx < 14) ? shadow_m[rd_idx] : 0;
            end
        end
        #1;
        check("rd_v_o", {63'd0, rd_v32}, {63'd0, exp_rdv});
        if (exp_rdv) begin
            check($sformatf("rd32[%0d]", rd_idx), {32'd0, rd_data32}, clamp(exp_rd, 32));
            check($sformatf("rd8[%0d]", rd_idx), {56'd0, rd_data8}, clamp(exp_rd, 8));
        end
    endtask

    task automatic idle();
        clear_inputs();
        tick();
    endtask

    task automatic snap();
        clear_inputs();
        snapshot = 1;
        tick();
        snapshot = 0;
    endtask

    task automatic rd(input int idx);
        clear_inputs();
        rd_v = 1;
        rd_idx = 4'(idx);
        tick();
        rd_v = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        reset_n = 0;
        @(negedge clk);
        tick();
        tick();
        check("reset_rd_data32", {32'd0, rd_data32}, 64'd0);
        check("reset_rd_v8", {63'd0, rd_v8}, 64'd0);
        reset_n = 1;

        // Three int remote_dram_load stalls.
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            int_rs1 = 5; int_rs1_v = 1; int_sb[5].remote_dram_load = 1; stall_depend = 1;
            tick();
        end
        snap();
        rd(1);  check("plan_dram_ld", {32'd0, rd_data32}, 64'd3);
        rd(13); check("plan_total", {32'd0, rd_data32}, 64'd3);
        rd(12); check("plan_max", {32'd0, rd_data32}, 64'd3);

        // Operand priority.
        clear_inputs();
        int_rs2 = 3; int_rs2_v = 1; int_sb[3].idiv = 1;
        float_rs1 = 3; float_rs1_v = 1; float_sb[3].fdiv_fsqrt = 1;
        stall_depend = 1;
        tick();
        clear_inputs();
        int_rs1 = 7; int_rs1_v = 1; int_sb[7].remote_group_load = 1; int_sb[7].remote_dram_amo = 1;
        int_rs2 = 3; int_rs2_v = 1; int_sb[3].idiv = 1;
        stall_depend = 1;
        tick();
        snap();
        rd(0); check("prio_idiv", {32'd0, rd_data32}, 64'd1);
        rd(3); check("prio_group", {32'd0, rd_data32}, 64'd1);
        rd(4); check("prio_amo", {32'd0, rd_data32}, 64'd0);
        rd(6); check("prio_fdiv", {32'd0, rd_data32}, 64'd0);

        // x0 never hazards: falls to unknown.
        clear_inputs();
        int_rs1 = 0; int_rs1_v = 1; int_sb[0] = '1; stall_depend = 1;
        tick();
        snap();
        rd(11); check("x0_unknown", {32'd0, rd_data32}, 64'd1);
        rd(0);  check("x0_idiv", {32'd0, rd_data32}, 64'd0);

        // Gating and run length: 2 counted, stall_all, 2 counted, idle, 1 counted, flushed stall.
        clear_inputs(); stall_depend = 1; tick(); tick();
        clear_inputs(); stall_all = 1; stall_depend = 1; tick();
        clear_inputs(); stall_depend = 1; tick(); tick();
        idle();
        clear_inputs(); stall_depend = 1; tick();
        clear_inputs(); stall_depend = 1; flush = 1; tick();
        snap();
        rd(12); check("gate_max", {32'd0, rd_data32}, 64'd4);
        rd(13); check("gate_total", {32'd0, rd_data32}, 64'd5);
        rd(11); check("gate_unknown", {32'd0, rd_data32}, 64'd5);

        // Snapshot on a counted cycle with a same-cycle read.
        clear_inputs(); stall_depend = 1; tick(); tick();
        clear_inputs(); stall_depend = 1; snapshot = 1; rd_v = 1; rd_idx = 13; tick();
        check("snap_capture", {32'd0, rd_data32}, 64'd3);
        snap();
        rd(13); check("snap_live_zero", {32'd0, rd_data32}, 64'd0);

        // Saturation on category 7.
        for (int i = 0; i < 300; i++) begin
            clear_inputs();
            float_rs1 = 2; float_rs1_v = 1; float_sb[2].remote_dram_load = 1; stall_depend = 1;
            tick();
        end
        snap();
        rd(7);  check("sat8_cat7", {56'd0, rd_data8}, 64'd255);
                check("sat32_cat7", {32'd0, rd_data32}, 64'd300);
        rd(12); check("sat8_max", {56'd0, rd_data8}, 64'd255);
        rd(13); check("sat8_total", {56'd0, rd_data8}, 64'd255);

        // Random traffic with occasional snapshots and reads.
        for (int c = 0; c < 600; c++) begin
            clear_inputs();
            stall_depend = ($urandom_range(0, 9) < 7);
            stall_all    = ($urandom_range(0, 9) == 0);
            flush        = ($urandom_range(0, 9) == 0);
            int_rs1 = AW'($urandom); int_rs2 = AW'($urandom); int_rd = AW'($urandom);
            if ($urandom_range(0, 3) == 0) int_rs1 = 0;
            float_rs1 = AW'($urandom); float_rs2 = AW'($urandom);
            float_rs3 = AW'($urandom); float_rd = AW'($urandom);
            {int_rs1_v, int_rs2_v, int_rd_v} = 3'($urandom);
            {float_rs1_v, float_rs2_v, float_rs3_v, float_rd_v} = 4'($urandom);
            for (int i = 0; i < reg_els_gp; i++) begin
                if ($urandom_range(0, 2) == 0) int_sb[i]   = vanilla_isb_info_s'(6'($urandom));
                if ($urandom_range(0, 2) == 0) float_sb[i] = vanilla_fsb_info_s'(5'($urandom));
            end
            snapshot = ($urandom_range(0, 39) == 0);
            rd_v     = ($urandom_range(0, 2) == 0);
            rd_idx   = 4'($urandom);
            tick();
        end
        snap();
        for (int k = 0; k < 16; k++) rd(k);

        // Reset mid-run with a read pending.
        clear_inputs(); stall_depend = 1; tick(); tick();
        clear_inputs(); stall_depend = 1; rd_v = 1; rd_idx = 13; reset_n = 0;
        tick();
        check("rst_rd_v", {63'd0, rd_v32}, 64'd0);
        check("rst_rd_data", {32'd0, rd_data32}, 64'd0);
        reset_n = 1;
        for (int k = 0; k < 16; k++) begin
            rd(k);
            check($sformatf("post_rst[%0d]", k), {32'd0, rd_data32}, 64'd0);
        end
        snap();
        rd(13); check("post_rst_total", {32'd0, rd_data32}, 64'd0);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
